// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch MM:SS counter.
// Segment patterns are active-low, bit0 = a ... bit6 = g, bit7 = dp.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned SEC_MAX = 59;

  // Seconds limit split into its two BCD digits.
  localparam bcd_t SEC_TENS_MAX = bcd_t'(SEC_MAX / 10);
  localparam bcd_t SEC_ONES_MAX = bcd_t'(SEC_MAX % 10);

  localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/stopwatch_counter_bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to active-low 7-segment pattern.
// Non-decimal inputs (10-15) produce a blank digit.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Decode one BCD digit into segments a..g (dp is handled by the caller).
  always_comb begin
    seg_o = SEG_BLANK[6:0];
    case (bcd_i)
      4'd0:    seg_o = SEG_0[6:0];
      4'd1:    seg_o = SEG_1[6:0];
      4'd2:    seg_o = SEG_2[6:0];
      4'd3:    seg_o = SEG_3[6:0];
      4'd4:    seg_o = SEG_4[6:0];
      4'd5:    seg_o = SEG_5[6:0];
      4'd6:    seg_o = SEG_6[6:0];
      4'd7:    seg_o = SEG_7[6:0];
      4'd8:    seg_o = SEG_8[6:0];
      4'd9:    seg_o = SEG_9[6:0];
      default: seg_o = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD MM:SS stopwatch with run/pause and 2 Hz field adjust.
// Drives registered active-low segment patterns for the display multiplexer.
// Optional feature: define COLON_DP_EN to blink digit2's dp as a colon.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] digit0_display,
  output logic [7:0] digit1_display,
  output logic [7:0] digit2_display,
  output logic [7:0] digit3_display,
  output logic       running
);

  localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MIN_ONES_MAX = bcd_t'(MAX_MIN % 10);

  bcd_t sec_ones_q, sec_ones_d;
  bcd_t sec_tens_q, sec_tens_d;
  bcd_t min_ones_q, min_ones_d;
  bcd_t min_tens_q, min_tens_d;
  logic running_q, running_d;

  // Incremented field values (with wrap), shared by RUN and ADJUST paths.
  bcd_t sec_inc_ones, sec_inc_tens;
  bcd_t min_inc_ones, min_inc_tens;
  logic sec_at_max, min_at_max;

  logic [6:0] seg0, seg1, seg2, seg3;
  logic [6:0] digit0_q, digit1_q, digit2_q, digit3_q;

  // Next value of seconds and minutes if each field were stepped by one.
  always_comb begin
    sec_at_max = (sec_tens_q == SEC_TENS_MAX) && (sec_ones_q == SEC_ONES_MAX);
    min_at_max = (min_tens_q == MIN_TENS_MAX) && (min_ones_q == MIN_ONES_MAX);
    sec_inc_ones = sec_ones_q;
    sec_inc_tens = sec_tens_q;
    min_inc_ones = min_ones_q;
    min_inc_tens = min_tens_q;
    if (sec_at_max) begin
      sec_inc_ones = 4'd0;
      sec_inc_tens = 4'd0;
    end else if (sec_ones_q == BCD_NINE) begin
      sec_inc_ones = 4'd0;
      sec_inc_tens = sec_tens_q + 4'd1;
    end else begin
      sec_inc_ones = sec_ones_q + 4'd1;
    end
    if (min_at_max) begin
      min_inc_ones = 4'd0;
      min_inc_tens = 4'd0;
    end else if (min_ones_q == BCD_NINE) begin
      min_inc_ones = 4'd0;
      min_inc_tens = min_tens_q + 4'd1;
    end else begin
      min_inc_ones = min_ones_q + 4'd1;
    end
  end

  // Mode logic: adjust steps one field on tick_2hz, run counts on tick_1hz.
  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    // Toggle is recorded in every mode; a same-cycle tick sees the old value.
    running_d  = running_q ^ pause;
    if (adj) begin
      if (tick_2hz) begin
        if (sel) begin
          sec_ones_d = sec_inc_ones;
          sec_tens_d = sec_inc_tens;
        end else begin
          min_ones_d = min_inc_ones;
          min_tens_d = min_inc_tens;
        end
      end else begin
        sec_ones_d = sec_ones_q;
      end
    end else if (running_q && tick_1hz) begin
      sec_ones_d = sec_inc_ones;
      sec_tens_d = sec_inc_tens;
      if (sec_at_max) begin
        min_ones_d = min_inc_ones;
        min_tens_d = min_inc_tens;
      end else begin
        min_ones_d = min_ones_q;
      end
    end else begin
      sec_ones_d = sec_ones_q;
    end
  end

  // Count and run-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b1;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
    end
  end

  bcd_to_seg u_seg0 (.bcd_i(sec_ones_q), .seg_o(seg0));
  bcd_to_seg u_seg1 (.bcd_i(sec_tens_q), .seg_o(seg1));
  bcd_to_seg u_seg2 (.bcd_i(min_ones_q), .seg_o(seg2));
  bcd_to_seg u_seg3 (.bcd_i(min_tens_q), .seg_o(seg3));

  // Segment registers: display lags the count by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit0_q <= SEG_0[6:0];
      digit1_q <= SEG_0[6:0];
      digit2_q <= SEG_0[6:0];
      digit3_q <= SEG_0[6:0];
    end else begin
      digit0_q <= seg0;
      digit1_q <= seg1;
      digit2_q <= seg2;
      digit3_q <= seg3;
    end
  end

`ifdef COLON_DP_EN
  logic colon_q, colon_d;

  // Colon blinks at 2 Hz while counting, stays lit otherwise.
  always_comb begin
    colon_d = colon_q;
    if (adj || !running_q) begin
      colon_d = 1'b0;
    end else if (tick_2hz) begin
      colon_d = ~colon_q;
    end else begin
      colon_d = colon_q;
    end
  end

  // Colon register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colon_q <= 1'b0;
    end else begin
      colon_q <= colon_d;
    end
  end

  assign digit2_display = {colon_q, digit2_q};
`else
  assign digit2_display = {1'b1, digit2_q};
`endif

  assign digit0_display = {1'b1, digit0_q};
  assign digit1_display = {1'b1, digit1_q};
  assign digit3_display = {1'b1, digit3_q};
  assign running        = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed testbench for stopwatch_counter (default MAX_MIN = 59).
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst, tick_1hz, tick_2hz, pause, adj, sel;
  logic [7:0] d0, d1, d2, d3;
  logic running;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] seg_tab [10];
  logic [31:0] disp;

`ifdef COLON_DP_EN
  localparam logic [31:0] DISP_MASK = 32'hFF7F_FFFF;
`else
  localparam logic [31:0] DISP_MASK = 32'hFFFF_FFFF;
`endif

  stopwatch_counter #(.MAX_MIN(59)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause(pause), .adj(adj), .sel(sel),
    .digit0_display(d0), .digit1_display(d1),
    .digit2_display(d2), .digit3_display(d3),
    .running(running)
  );

  always #5 clk = ~clk;

  assign disp = {d3, d2, d1, d0} & DISP_MASK;

  function automatic logic [31:0] exp_disp(input int mm, input int ss);
    return {seg_tab[mm / 10], seg_tab[mm % 10], seg_tab[ss / 10], seg_tab[ss % 10]} & DISP_MASK;
  endfunction

  // One-cycle pulse on the chosen inputs, then wait so the display has settled.
  task automatic pulse(input logic t1, input logic t2, input logic p);
    @(negedge clk);
    tick_1hz = t1; tick_2hz = t2; pause = p;
    @(negedge clk);
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulses_2hz(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; pause = 1'b0; adj = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (disp !== (32'hC0C0C0C0 & DISP_MASK)) $display("FAIL reset_disp got %h want %h", disp, 32'hC0C0C0C0 & DISP_MASK);
    else pass_cnt++;
    total_cnt++;
    if (running !== 1'b1) $display("FAIL reset_running got %b want 1", running);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      total_cnt++;
      if (disp !== exp_disp(0, i - 1)) $display("FAIL count_latency%0d got %h want %h", i, disp, exp_disp(0, i - 1));
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (disp !== exp_disp(0, i)) $display("FAIL count_step%0d got %h want %h", i, disp, exp_disp(0, i));
      else pass_cnt++;
    end
    total_cnt++;
    if (d0 !== 8'hB0 || d1 !== 8'hC0 || running !== 1'b1)
      $display("FAIL count_final got d0=%h d1=%h run=%b want B0 C0 1", d0, d1, running);
    else pass_cnt++;
  endtask

  task automatic test_carry;
    adj = 1'b1; sel = 1'b1;
    pulses_2hz(56);
    total_cnt++;
    if (disp !== exp_disp(0, 59)) $display("FAIL preload_0059 got %h want %h", disp, exp_disp(0, 59));
    else pass_cnt++;
    adj = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 0) || d2 !== 8'hF9) $display("FAIL carry_0100 got %h want %h", disp, exp_disp(1, 0));
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    adj = 1'b1; sel = 1'b0;
    pulses_2hz(58);
    sel = 1'b1;
    pulses_2hz(59);
    total_cnt++;
    if (disp !== exp_disp(59, 59)) $display("FAIL preload_5959 got %h want %h", disp, exp_disp(59, 59));
    else pass_cnt++;
    adj = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(0, 0)) $display("FAIL wrap_0000 got %h want %h", disp, exp_disp(0, 0));
    else pass_cnt++;
  endtask

  task automatic test_pause;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (running !== 1'b0) $display("FAIL pause_running got %b want 0", running);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(0, 0)) $display("FAIL pause_frozen got %h want %h", disp, exp_disp(0, 0));
    else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(0, 1) || running !== 1'b1) $display("FAIL resume_count got %h run=%b want %h 1", disp, running, exp_disp(0, 1));
    else pass_cnt++;
    pulse(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (disp !== exp_disp(0, 2) || running !== 1'b0) $display("FAIL pause_tick_same got %h run=%b want %h 0", disp, running, exp_disp(0, 2));
    else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (running !== 1'b1) $display("FAIL rerun got %b want 1", running);
    else pass_cnt++;
  endtask

  task automatic test_colon;
`ifdef COLON_DP_EN
    logic before;
    before = d2[7];
    pulse(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (d2[7] !== ~before) $display("FAIL colon_toggle got %b want %b", d2[7], ~before);
    else pass_cnt++;
`else
    pulse(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(0, 2) || (disp & 32'h80808080) !== 32'h80808080)
      $display("FAIL run_2hz_dp got %h want %h", disp, exp_disp(0, 2));
    else pass_cnt++;
`endif
  endtask

  task automatic test_adjust;
    adj = 1'b1; sel = 1'b0;
    pulses_2hz(58);
    total_cnt++;
    if (disp !== exp_disp(58, 2)) $display("FAIL adj_min58 got %h want %h", disp, exp_disp(58, 2));
    else pass_cnt++;
    pulse(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(59, 2)) $display("FAIL adj_min59 got %h want %h", disp, exp_disp(59, 2));
    else pass_cnt++;
    pulse(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(0, 2)) $display("FAIL adj_min_wrap got %h want %h", disp, exp_disp(0, 2));
    else pass_cnt++;
    pulse(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 2)) $display("FAIL adj_min01 got %h want %h", disp, exp_disp(1, 2));
    else pass_cnt++;
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 2)) $display("FAIL adj_ignore_1hz got %h want %h", disp, exp_disp(1, 2));
    else pass_cnt++;
    sel = 1'b1;
    pulses_2hz(57);
    total_cnt++;
    if (disp !== exp_disp(1, 59)) $display("FAIL adj_sec59 got %h want %h", disp, exp_disp(1, 59));
    else pass_cnt++;
    pulse(1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 0)) $display("FAIL adj_sec_wrap got %h want %h", disp, exp_disp(1, 0));
    else pass_cnt++;
    pulse(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 1)) $display("FAIL adj_both_ticks got %h want %h", disp, exp_disp(1, 1));
    else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    adj = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 1) || running !== 1'b0) $display("FAIL adj_pause_kept got %h run=%b want %h 0", disp, running, exp_disp(1, 1));
    else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(1, 2)) $display("FAIL adj_exit_count got %h want %h", disp, exp_disp(1, 2));
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    pulse(1'b0, 1'b0, 1'b1);
    adj = 1'b1; sel = 1'b0;
    pulses_2hz(11);
    sel = 1'b1;
    pulses_2hz(32);
    adj = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (disp !== exp_disp(12, 34) || running !== 1'b0) $display("FAIL preload_1234 got %h run=%b want %h 0", disp, running, exp_disp(12, 34));
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (disp !== (32'hC0C0C0C0 & DISP_MASK) || running !== 1'b1)
      $display("FAIL async_reset got %h run=%b want %h 1", disp, running, 32'hC0C0C0C0 & DISP_MASK);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (disp !== exp_disp(0, 1)) $display("FAIL post_reset_tick got %h want %h", disp, exp_disp(0, 1));
    else pass_cnt++;
  endtask

  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
    test_reset();
    test_count();
    test_carry();
    test_wrap();
    test_pause();
    test_colon();
    test_adjust();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
